demux_1to8_deser: RTL and testbench

Receive-side counterpart of the 8-to-1 mux datapath. It accepts a 1-bit serial stream, demultiplexes it onto eight lane bits (lane 0 = input a … lane 7 = input h) and presents the completed 8-bit frame to the consumer over a valid/ready handshake. It also supports a direct addressed mode, where an external 3-bit select steers each bit to one lane, mirroring the mux's select encoding. It sits between the serial link and the parallel register file in the lab datapath.

---
 rtl/demux_1to8_deser_pkg.sv | 27 ++
 rtl/demux_1to8_deser_if.sv | 25 ++
 rtl/demux_1to8_deser_slot_counter.sv | 37 +++
 rtl/demux_1to8_deser.sv | 91 +++++++++
 tb/tb_demux_1to8_deser.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/demux_1to8_deser_pkg.sv
// Shared definitions for the 1-to-8 deserialising demux:
// lane/slot widths, mode and FSM encodings, and a lane-write helper.
package demux_pkg;

  localparam int LANES  = 8;
  localparam int SLOT_W = 3;

  localparam logic MODE_SCAN = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic logic [LANES-1:0] set_lane(
    input logic [LANES-1:0]  word,
    input logic [SLOT_W-1:0] idx,
    input logic              bit_val
  );
    logic [LANES-1:0] res;
    res      = word;
    res[idx] = bit_val;
    return res;
  endfunction

endpackage

// File: rtl/demux_1to8_deser_if.sv
// Serial-in / parallel-out bundle of the deserialising demux.
// slave = the demux, master = the stream source plus frame consumer.
interface demux_1to8_deser_if;
  import demux_pkg::*;

  logic              din;
  logic              din_valid;
  logic              mode;
  logic [SLOT_W-1:0] sel;
  logic              frame_ready;
  logic [LANES-1:0]  lanes;
  logic              frame_valid;
  logic [SLOT_W-1:0] slot;
  logic              overrun;

  modport slave (
    input  din, din_valid, mode, sel, frame_ready,
    output lanes, frame_valid, slot, overrun
  );

  modport master (
    output din, din_valid, mode, sel, frame_ready,
    input  lanes, frame_valid, slot, overrun
  );
endinterface

// File: rtl/demux_1to8_deser_slot_counter.sv
// Modulo-8 scan slot counter. When clear and enable coincide, the beat is
// treated as landing in slot 0, so the counter moves straight on to 1.
module slot_counter
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  output logic [SLOT_W-1:0] count,
  output logic              wrap
);

  // Wrap strobe: a beat is written into the last slot.
  always_comb begin
    wrap = 1'b0;
    if (en && !clr && (count == 3'd7)) begin
      wrap = 1'b1;
    end else begin
      wrap = 1'b0;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (clr) begin
      count <= en ? 3'd1 : 3'd0;
    end else if (en) begin
      count <= count + 3'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/demux_1to8_deser.sv
// 1-to-8 demux/deserialiser: scan mode assembles 8-bit frames handed out over
// valid/ready; addressed mode writes single lanes chosen by sel.
module demux_1to8_deser
  import demux_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1to8_deser_if.slave   bus
);

  logic              mode_r;
  state_e            state_r;
  logic [LANES-1:0]  shadow_r;
  logic [LANES-1:0]  lanes_r;
  logic              overrun_r;

  logic              scan_s;
  logic              mode_chg_s;
  logic              beat_s;
  logic              accept_s;
  logic              wrap_s;
  logic [SLOT_W-1:0] cnt_s;
  logic [SLOT_W-1:0] eff_slot_s;
  logic [LANES-1:0]  shadow_next_s;

  slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (beat_s),
    .clr   (mode_chg_s | ~scan_s),
    .count (cnt_s),
    .wrap  (wrap_s)
  );

  // A mode change discards the partial frame before this cycle's bit lands.
  always_comb begin
    scan_s        = (bus.mode == MODE_SCAN);
    mode_chg_s    = (bus.mode != mode_r);
    beat_s        = bus.din_valid & scan_s;
    accept_s      = (state_r == ST_FULL) & bus.frame_ready;
    eff_slot_s    = mode_chg_s ? 3'd0 : cnt_s;
    shadow_next_s = mode_chg_s ? {LANES{1'b0}} : shadow_r;
    if (beat_s) begin
      shadow_next_s = set_lane(shadow_next_s, eff_slot_s, bus.din);
    end else begin
      shadow_next_s = shadow_next_s;
    end
  end

  // Frame FSM, output register and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r    <= MODE_SCAN;
      state_r   <= ST_EMPTY;
      shadow_r  <= {LANES{1'b0}};
      lanes_r   <= {LANES{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      mode_r   <= bus.mode;
      shadow_r <= shadow_next_s;
      if (!scan_s) begin
        state_r <= ST_EMPTY;
        if (bus.din_valid) begin
          lanes_r <= set_lane(lanes_r, bus.sel, bus.din);
        end else begin
          lanes_r <= lanes_r;
        end
      end else if (wrap_s) begin
        // Completion alongside a handshake is accept-then-load.
        if ((state_r == ST_EMPTY) || accept_s) begin
          lanes_r <= shadow_next_s;
          state_r <= ST_FULL;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (accept_s) begin
        state_r <= ST_EMPTY;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.lanes       = lanes_r;
  assign bus.frame_valid = (state_r == ST_FULL);
  assign bus.slot        = cnt_s;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Directed self-checking bench for demux_1to8_deser.
module tb_demux_1to8_deser;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  demux_1to8_deser_if bus ();

  demux_1to8_deser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    bus.din       = b;
    bus.din_valid = 1'b1;
    step();
  endtask

  task automatic send_frame(input logic [7:0] f);
    for (int i = 0; i < 8; i++) beat(f[i]);
    bus.din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] pair;
    int          nv;
    int          idx[2];
    logic [7:0]  dat[2];
    int          fv_seen;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.mode = 1'b0;
    bus.sel = 3'd0; bus.frame_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.din = 1'($urandom); bus.din_valid = 1'($urandom);
      bus.mode = 1'($urandom); bus.sel = 3'($urandom);
      bus.frame_ready = 1'($urandom);
      step();
    end
    check_val("rst_lanes", bus.lanes, 8'h00);
    check_val("rst_fv", {7'd0, bus.frame_valid}, 8'h00);
    check_val("rst_slot", {5'd0, bus.slot}, 8'h00);
    check_val("rst_ovr", {7'd0, bus.overrun}, 8'h00);

    // Scan frame 0x69 (din 1,0,0,1,0,1,1,0)
    rst_n = 1'b1; bus.mode = 1'b0; bus.frame_ready = 1'b0;
    bus.din_valid = 1'b0; step();
    beat(1'b1); beat(1'b0); beat(1'b0);
    check_val("scan_slot3", {5'd0, bus.slot}, 8'h03);
    check_val("scan_fv_mid", {7'd0, bus.frame_valid}, 8'h00);
    beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b1); beat(1'b0);
    bus.din_valid = 1'b0;
    check_val("scan_lanes", bus.lanes, 8'h69);
    check_val("scan_fv", {7'd0, bus.frame_valid}, 8'h01);
    check_val("scan_slot_wrap", {5'd0, bus.slot}, 8'h00);
    bus.frame_ready = 1'b1; step(); bus.frame_ready = 1'b0;
    check_val("scan_accept_fv", {7'd0, bus.frame_valid}, 8'h00);
    check_val("scan_hold_lanes", bus.lanes, 8'h69);

    // Overrun: 0x69 held, then 0xFF dropped
    send_frame(8'h69);
    check_val("ovr_first_fv", {7'd0, bus.frame_valid}, 8'h01);
    send_frame(8'hFF);
    check_val("ovr_lanes", bus.lanes, 8'h69);
    check_val("ovr_flag", {7'd0, bus.overrun}, 8'h01);
    check_val("ovr_fv_held", {7'd0, bus.frame_valid}, 8'h01);
    bus.frame_ready = 1'b1; step(); bus.frame_ready = 1'b0;
    check_val("ovr_accept_fv", {7'd0, bus.frame_valid}, 8'h00);
    check_val("ovr_sticky", {7'd0, bus.overrun}, 8'h01);

    // Back-to-back A5 then 3C with frame_ready held high
    do_reset();
    bus.frame_ready = 1'b1;
    pair = 16'h3CA5;
    nv = 0; idx[0] = -1; idx[1] = -1; dat[0] = 8'h00; dat[1] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      beat(pair[i]);
      if (bus.frame_valid) begin
        if (nv < 2) begin
          idx[nv] = i;
          dat[nv] = bus.lanes;
        end
        nv++;
      end
    end
    bus.din_valid = 1'b0;
    check_val("b2b_count", 8'(nv), 8'd2);
    check_val("b2b_idx0", 8'(idx[0]), 8'd7);
    check_val("b2b_idx1", 8'(idx[1]), 8'd15);
    check_val("b2b_dat0", dat[0], 8'hA5);
    check_val("b2b_dat1", dat[1], 8'h3C);
    check_val("b2b_ovr", {7'd0, bus.overrun}, 8'h00);
    bus.frame_ready = 1'b0;

    // Addressed writes to lanes 0,3,5,6
    do_reset();
    bus.mode = 1'b1;
    fv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: bus.sel = 3'd0;
        1: bus.sel = 3'd3;
        2: bus.sel = 3'd5;
        default: bus.sel = 3'd6;
      endcase
      beat(1'b1);
      if (bus.frame_valid) fv_seen++;
      if (i == 1) check_val("addr_partial", bus.lanes, 8'h09);
    end
    bus.din = 1'b0; bus.sel = 3'd3; bus.din_valid = 1'b0; step();
    check_val("addr_lanes", bus.lanes, 8'h69);
    check_val("addr_fv_never", 8'(fv_seen), 8'd0);
    check_val("addr_slot", {5'd0, bus.slot}, 8'h00);

    // Mode switch mid-frame
    do_reset();
    bus.mode = 1'b0;
    beat(1'b1); beat(1'b1); beat(1'b1);
    check_val("msw_slot3", {5'd0, bus.slot}, 8'h03);
    bus.mode = 1'b1; bus.din_valid = 1'b0; step();
    check_val("msw_slot_clr", {5'd0, bus.slot}, 8'h00);
    bus.mode = 1'b0;
    send_frame(8'hA5);
    check_val("msw_lanes", bus.lanes, 8'hA5);
    check_val("msw_fv", {7'd0, bus.frame_valid}, 8'h01);
    check_val("msw_slot", {5'd0, bus.slot}, 8'h00);
    bus.frame_ready = 1'b1; step(); bus.frame_ready = 1'b0;

    // Reset after 5 beats: partial frame lost
    for (int i = 0; i < 5; i++) beat(1'b1);
    bus.din_valid = 1'b0;
    check_val("rmid_slot5", {5'd0, bus.slot}, 8'h05);
    do_reset();
    check_val("rmid_slot", {5'd0, bus.slot}, 8'h00);
    fv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1);
      if (bus.frame_valid) fv_seen++;
    end
    bus.din_valid = 1'b0;
    check_val("rmid_no_frame", 8'(fv_seen), 8'd0);
    check_val("rmid_slot_after", {5'd0, bus.slot}, 8'h03);
    check_val("rmid_lanes", bus.lanes, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
